sar_logic: RTL and testbench

//  Synchronous SAR control logic; consumes the sense-amp decision (vop/von/done), drives its asyn_clk.
//  Per conversion: sample phase, then NBITS binary-search trials MSB->LSB on the cap-DAC code.

---
 rtl/sar_logic.sv | 241 ++++++++++++++++++++++++
 tb/tb_sar_logic.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_logic.sv
// ---------------------------------------------------------------------------
// sar_logic
// Synchronous successive-approximation control logic. Each conversion runs a
// sample phase and then NBITS binary-search trials from MSB to LSB on the
// cap-DAC code. The sense amplifier is clocked through cmp_clk, and its
// decision (vop/done) sets each trial bit.
//
// Optional feature macro: SAR_TIMEOUT_EN
//   defined   : if done does not arrive within TIMEOUT_CYC cycles of CMP_HI,
//               the current bit is forced to 1, timeout_err is set (sticky
//               until the next accepted start or rst), and the search goes on.
//   undefined : CMP_HI waits for done without limit; timeout_err is always 0.
//
// Ports
//   clk          in   1      single clock, all state updates on posedge
//   rst          in   1      synchronous active-high reset
//   start        in   1      conversion request, only looked at in IDLE
//   vop          in   1      sense-amp positive output (1 => vip >= vin)
//   von          in   1      sense-amp negative output (complement of vop)
//   done         in   1      sense-amp decision valid
//   samp         out  1      sampling switch enable
//   cmp_clk      out  1      comparator clock (sense-amp asyn_clk)
//   dac_p        out  NBITS  trial code to the positive cap DAC
//   dac_n        out  NBITS  bitwise complement of dac_p
//   dout         out  NBITS  conversion result, held until the next result
//   dout_valid   out  1      one-cycle pulse when dout updates
//   busy         out  1      high in every state except IDLE
//   timeout_err  out  1      sticky forced-decision flag
// ---------------------------------------------------------------------------
module sar_logic #(
    parameter int NBITS       = 8,
    parameter int SAMPLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vop,
    input  logic             von,
    input  logic             done,
    output logic             samp,
    output logic             cmp_clk,
    output logic [NBITS-1:0] dac_p,
    output logic [NBITS-1:0] dac_n,
    output logic [NBITS-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             timeout_err
);

    localparam int IDX_W  = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int SCNT_W = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
    localparam int TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [NBITS-1:0] MSB_ONE = NBITS'(1) << (NBITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_CMP_HI = 3'd2,
        ST_CMP_LO = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    // Returns the code with the trial bit at position idx set.
    function automatic logic [NBITS-1:0] with_trial_bit(
        input logic [NBITS-1:0] code,
        input logic [IDX_W-1:0] idx
    );
        return code | (NBITS'(1) << idx);
    endfunction

    state_t             state_r,      state_nxt_s;
    logic               samp_r,       samp_nxt_s;
    logic               cmp_clk_r,    cmp_clk_nxt_s;
    logic [NBITS-1:0]   dac_p_r,      dac_p_nxt_s;
    logic [NBITS-1:0]   dac_n_r,      dac_n_nxt_s;
    logic [NBITS-1:0]   dout_r,       dout_nxt_s;
    logic               dout_valid_r, dout_valid_nxt_s;
    logic               busy_r,       busy_nxt_s;
    logic               terr_r,       terr_nxt_s;
    logic [NBITS-1:0]   code_r,       code_nxt_s;
    logic [IDX_W-1:0]   idx_r,        idx_nxt_s;
    logic [SCNT_W-1:0]  scnt_r,       scnt_nxt_s;
`ifdef SAR_TIMEOUT_EN
    logic [TCNT_W-1:0]  tcnt_r,       tcnt_nxt_s;
`else
    // Without the timeout there is no counter; keep its width parameter tied off.
    logic [TCNT_W-1:0]  tmo_unused_s;
    assign tmo_unused_s = {TCNT_W{1'b0}};
`endif

    // von is the complement of vop by construction; the decision uses vop alone.
    logic sense_unused_s;
    assign sense_unused_s = von;

    // Next-state and next-output logic; every register holds unless a state changes it.
    always_comb begin
        state_nxt_s      = state_r;
        samp_nxt_s       = samp_r;
        cmp_clk_nxt_s    = cmp_clk_r;
        dac_p_nxt_s      = dac_p_r;
        dout_nxt_s       = dout_r;
        dout_valid_nxt_s = 1'b0;
        busy_nxt_s       = busy_r;
        terr_nxt_s       = terr_r;
        code_nxt_s       = code_r;
        idx_nxt_s        = idx_r;
        scnt_nxt_s       = scnt_r;
`ifdef SAR_TIMEOUT_EN
        tcnt_nxt_s       = tcnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SAMPLE;
                    samp_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b1;
                    code_nxt_s  = {NBITS{1'b0}};
                    terr_nxt_s  = 1'b0;
                    scnt_nxt_s  = {SCNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_SAMPLE: begin
                if (scnt_r == SCNT_W'(SAMPLE_CYC - 1)) begin
                    state_nxt_s   = ST_CMP_HI;
                    samp_nxt_s    = 1'b0;
                    cmp_clk_nxt_s = 1'b1;
                    dac_p_nxt_s   = MSB_ONE;
                    idx_nxt_s     = IDX_W'(NBITS - 1);
`ifdef SAR_TIMEOUT_EN
                    tcnt_nxt_s    = {TCNT_W{1'b0}};
`endif
                end else begin
                    scnt_nxt_s = scnt_r + SCNT_W'(1);
                end
            end
            ST_CMP_HI: begin
                // A done already high on entry is taken in the same cycle.
                if (done) begin
                    code_nxt_s[idx_r] = vop;
                    cmp_clk_nxt_s     = 1'b0;
                    state_nxt_s       = ST_CMP_LO;
`ifdef SAR_TIMEOUT_EN
                end else if (tcnt_r == TCNT_W'(TIMEOUT_CYC - 1)) begin
                    // Comparator never resolved: keep the trial bit and flag it.
                    code_nxt_s[idx_r] = 1'b1;
                    cmp_clk_nxt_s     = 1'b0;
                    terr_nxt_s        = 1'b1;
                    state_nxt_s       = ST_CMP_LO;
                end else begin
                    tcnt_nxt_s = tcnt_r + TCNT_W'(1);
                end
`else
                end else begin
                    state_nxt_s = ST_CMP_HI;
                end
`endif
            end
            ST_CMP_LO: begin
                // One low cycle lets the sense amp reset and drop done.
                if (idx_r == IDX_W'(0)) begin
                    state_nxt_s      = ST_OUT;
                    dout_nxt_s       = code_r;
                    dout_valid_nxt_s = 1'b1;
                end else begin
                    idx_nxt_s     = idx_r - IDX_W'(1);
                    dac_p_nxt_s   = with_trial_bit(code_r, idx_r - IDX_W'(1));
                    cmp_clk_nxt_s = 1'b1;
                    state_nxt_s   = ST_CMP_HI;
`ifdef SAR_TIMEOUT_EN
                    tcnt_nxt_s    = {TCNT_W{1'b0}};
`endif
                end
            end
            ST_OUT: begin
                state_nxt_s = ST_IDLE;
                dac_p_nxt_s = {NBITS{1'b0}};
                busy_nxt_s  = 1'b0;
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                samp_nxt_s    = 1'b0;
                cmp_clk_nxt_s = 1'b0;
                dac_p_nxt_s   = {NBITS{1'b0}};
                busy_nxt_s    = 1'b0;
            end
        endcase
        dac_n_nxt_s = ~dac_p_nxt_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            samp_r       <= 1'b0;
            cmp_clk_r    <= 1'b0;
            dac_p_r      <= {NBITS{1'b0}};
            dac_n_r      <= {NBITS{1'b1}};
            dout_r       <= {NBITS{1'b0}};
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            terr_r       <= 1'b0;
            code_r       <= {NBITS{1'b0}};
            idx_r        <= IDX_W'(NBITS - 1);
            scnt_r       <= {SCNT_W{1'b0}};
`ifdef SAR_TIMEOUT_EN
            tcnt_r       <= {TCNT_W{1'b0}};
`endif
        end else begin
            state_r      <= state_nxt_s;
            samp_r       <= samp_nxt_s;
            cmp_clk_r    <= cmp_clk_nxt_s;
            dac_p_r      <= dac_p_nxt_s;
            dac_n_r      <= dac_n_nxt_s;
            dout_r       <= dout_nxt_s;
            dout_valid_r <= dout_valid_nxt_s;
            busy_r       <= busy_nxt_s;
            terr_r       <= terr_nxt_s;
            code_r       <= code_nxt_s;
            idx_r        <= idx_nxt_s;
            scnt_r       <= scnt_nxt_s;
`ifdef SAR_TIMEOUT_EN
            tcnt_r       <= tcnt_nxt_s;
`endif
        end
    end

    assign samp        = samp_r;
    assign cmp_clk     = cmp_clk_r;
    assign dac_p       = dac_p_r;
    assign dac_n       = dac_n_r;
    assign dout        = dout_r;
    assign dout_valid  = dout_valid_r;
    assign busy        = busy_r;
    assign timeout_err = terr_r;

endmodule

// File: tb/tb_sar_logic.sv
// Self-checking bench for sar_logic (NBITS=8, SAMPLE_CYC=2, TIMEOUT_CYC=4).
// A timeline model predicts every output from the cycle number since the
// accepted start and the binary-search result; directed tests add literal
// expectations for latency, results and reset/ignore/stuck behaviour.
module tb_sar_logic;

    localparam int NB   = 8;
    localparam int SCYC = 2;
    localparam int TCYC = 4;
`ifdef SAR_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif
    // Length of CMP_HI for the stuck bit (effectively forever without timeout).
    localparam int HI_STUCK = TMO ? TCYC : 100000;

    logic          clk, rst, start, vop, von, done;
    logic          samp, cmp_clk, dout_valid, busy, timeout_err;
    logic [NB-1:0] dac_p, dac_n, dout;

    int checks = 0;
    int errors = 0;
    int vin_code = 0;
    int stuck_bit = -1;

    // model state
    int cyc = 0;
    int k = 0;
    int conv_stuck = -1;
    int exp_res = 0;
    int exp_dout = 0;
    bit exp_terr = 1'b0;
    int dv_cyc[$];

    sar_logic #(.NBITS(NB), .SAMPLE_CYC(SCYC), .TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .rst(rst), .start(start), .vop(vop), .von(von), .done(done),
        .samp(samp), .cmp_clk(cmp_clk), .dac_p(dac_p), .dac_n(dac_n),
        .dout(dout), .dout_valid(dout_valid), .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Final code of a binary search; a stuck bit is forced to 1.
    function automatic int search(input int vin, input int st);
        int res = 0;
        for (int b = NB - 1; b >= 0; b--) begin
            if (b == st) res = res | (1 << b);
            else if (vin >= (res | (1 << b))) res = res | (1 << b);
        end
        return res;
    endfunction

    // DAC code while bit b is on trial, given the final result.
    function automatic int trial(input int res, input int b);
        return (res & ~((2 << b) - 1) & 255) | (1 << b);
    endfunction

    function automatic int hi_len(input int b, input int st);
        return (b == st) ? HI_STUCK : 1;
    endfunction

    // Cycle (1 = first cycle after start accepted) in which dout_valid pulses.
    function automatic int out_cyc(input int st);
        int t = SCYC + 1;
        for (int b = NB - 1; b >= 0; b--) t += hi_len(b, st) + 1;
        return t;
    endfunction

    // Bit on trial at cycle kk (>SCYC); -1 means the output cycle.
    function automatic int locate(input int kk, input int st, output bit hi);
        int t = SCYC + 1;
        hi = 1'b0;
        for (int b = NB - 1; b >= 0; b--) begin
            if (kk < t + hi_len(b, st)) begin hi = 1'b1; return b; end
            t += hi_len(b, st);
            if (kk == t) return b;
            t += 1;
        end
        return -1;
    endfunction

    // Sense-amp model: decision half a cycle after cmp_clk rises, cleared while cmp_clk is low.
    always @(negedge clk) begin
        vop  = (vin_code >= int'(dac_p));
        von  = ~vop;
        done = cmp_clk && !(stuck_bit >= 0 &&
               ((int'(dac_p) & ((2 << stuck_bit) - 1)) == (1 << stuck_bit)));
    end

    // Timeline model and per-cycle compare.
    always @(posedge clk) begin : model
        int b;
        bit hi;
        int e_dac;
        bit e_samp, e_cmp, e_busy, e_dv;
        cyc++;
        if (rst) begin
            k = 0; exp_dout = 0; exp_terr = 1'b0;
        end else if (k == 0) begin
            if (start) begin
                k = 1; conv_stuck = stuck_bit; exp_terr = 1'b0;
                exp_res = search(vin_code, stuck_bit);
            end
        end else if (k == out_cyc(conv_stuck)) begin
            k = 0;
        end else begin
            k++;
        end
        e_samp = 1'b0; e_cmp = 1'b0; e_busy = 1'b0; e_dv = 1'b0; e_dac = 0;
        if (k >= 1 && k <= SCYC) begin
            e_samp = 1'b1; e_busy = 1'b1;
        end else if (k > SCYC) begin
            e_busy = 1'b1;
            b = locate(k, conv_stuck, hi);
            if (b >= 0) begin
                e_cmp = hi;
                e_dac = trial(exp_res, b);
                if (TMO && b == conv_stuck && !hi) exp_terr = 1'b1;
            end else begin
                e_dv = 1'b1;
                exp_dout = exp_res;
                e_dac = trial(exp_res, 0);
            end
        end
        #1;
        chk("samp", samp, e_samp);
        chk("cmp_clk", cmp_clk, e_cmp);
        chk("busy", busy, e_busy);
        chk("dout_valid", dout_valid, e_dv);
        chk("dout", dout, exp_dout);
        chk("dac_p", dac_p, e_dac);
        chk("dac_n", dac_n, (~e_dac) & 255);
        chk("timeout_err", timeout_err, exp_terr);
        if (dout_valid === 1'b1) dv_cyc.push_back(cyc);
    end

    task automatic wait_dv(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #2;
            if (dout_valid === 1'b1) begin seen = 1'b1; break; end
        end
    endtask

    initial begin : stim
        bit seen;
        int s_cyc, n0;
        rst = 1'b1; start = 1'b0; done = 1'b0; vop = 1'b0; von = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_dac_p", dac_p, 8'h00);
        chk("rst_dac_n", dac_n, 8'hFF);
        chk("rst_dout", dout, 8'h00);
        chk("rst_terr", timeout_err, 0);

        // single conversion, latency 2+16+1
        @(negedge clk); vin_code = 8'hA5; start = 1'b1; s_cyc = cyc;
        @(negedge clk); start = 1'b0;
        wait_dv(40, seen);
        chk("a5_seen", seen, 1);
        chk("a5_latency", dv_cyc[dv_cyc.size()-1] - s_cyc, 19);
        chk("a5_dout", dout, 8'hA5);
        repeat (3) @(negedge clk);

        // start pulsed during CMP_LO of bit 7 is ignored
        @(negedge clk); vin_code = 8'h3C; start = 1'b1; n0 = dv_cyc.size();
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        chk("lo_cmp_clk", cmp_clk, 0);
        chk("lo_busy", busy, 1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (30) @(negedge clk);
        chk("ignore_count", dv_cyc.size() - n0, 1);
        chk("3c_dout", dout, 8'h3C);

        // back-to-back with start held high
        @(negedge clk); vin_code = 8'hFF; start = 1'b1; n0 = dv_cyc.size();
        wait_dv(40, seen);
        chk("ff_seen", seen, 1);
        chk("ff_dout", dout, 8'hFF);
        @(negedge clk); vin_code = 8'h00;
        @(negedge clk);
        @(negedge clk); start = 1'b0;
        wait_dv(40, seen);
        chk("00_seen", seen, 1);
        chk("00_dout", dout, 8'h00);
        chk("b2b_gap", dv_cyc[dv_cyc.size()-1] - dv_cyc[dv_cyc.size()-2], 20);
        chk("b2b_count", dv_cyc.size() - n0, 2);
        repeat (2) @(negedge clk);

        // reset during CMP_HI of bit 4
        @(negedge clk); vin_code = 8'h5A; start = 1'b1; n0 = dv_cyc.size();
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        chk("b4_cmp_clk", cmp_clk, 1);
        chk("b4_dac_p", dac_p, 8'h50);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_cmp_clk", cmp_clk, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_dac_p", dac_p, 8'h00);
        chk("rstmid_dac_n", dac_n, 8'hFF);
        chk("rstmid_dv", dout_valid, 0);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("rstmid_no_dv", dv_cyc.size() - n0, 0);

        // comparator never answers on bit 3
        @(negedge clk); vin_code = 8'h00; stuck_bit = 3; start = 1'b1;
        s_cyc = cyc; n0 = dv_cyc.size();
        @(negedge clk); start = 1'b0;
`ifdef SAR_TIMEOUT_EN
        wait_dv(60, seen);
        chk("tmo_seen", seen, 1);
        chk("tmo_latency", dv_cyc[dv_cyc.size()-1] - s_cyc, 22);
        chk("tmo_dout", dout, 8'h08);
        chk("tmo_err", timeout_err, 1);
        repeat (3) @(negedge clk);
        chk("tmo_err_sticky", timeout_err, 1);
        stuck_bit = -1; vin_code = 8'h81; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("tmo_err_clr", timeout_err, 0);
        wait_dv(40, seen);
        chk("81_seen", seen, 1);
        chk("81_dout", dout, 8'h81);
`else
        repeat (40) @(negedge clk);
        chk("stuck_cmp_clk", cmp_clk, 1);
        chk("stuck_busy", busy, 1);
        chk("stuck_terr", timeout_err, 0);
        chk("stuck_dac_p", dac_p, 8'h08);
        chk("stuck_no_dv", dv_cyc.size() - n0, 0);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; stuck_bit = -1;
        chk("stuck_rst_busy", busy, 0);
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        errors++;
        $display("FAIL watchdog: got time limit, expected end of stimulus");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
